// File: rtl/jk_bank_pkg.sv
// Shared types and constants for the JK bank arbiter.
package jk_bank_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  typedef enum logic [OP_W-1:0] {
    OpHold  = 3'b000,
    OpClr   = 3'b001,
    OpSet   = 3'b010,
    OpTgl   = 3'b011,
    OpPulse = 3'b100
  } op_t;

  typedef enum logic [1:0] {
    StIdle,
    StApply,
    StRestore
  } state_t;

  // Codes above PULSE run as HOLD but are flagged on completion.
  function automatic logic op_illegal(logic [OP_W-1:0] op);
    return op > 3'b100;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop cell with asynchronous active-low reset to 0.
module jk_cell (
  input  logic CLK,
  input  logic RST_N,
  input  logic J,
  input  logic K,
  output logic Q,
  output logic QB
);

  logic q_q;

  // Standard JK behaviour: hold, clear, set, toggle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      q_q <= 1'b0;
    end else begin
      case ({J, K})
        2'b00:   q_q <= q_q;
        2'b01:   q_q <= 1'b0;
        2'b10:   q_q <= 1'b1;
        default: q_q <= ~q_q;
      endcase
    end
  end

  assign Q  = q_q;
  assign QB = ~q_q;

endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin two-requester controller driving a bank of JK cells with masked bit operations.
module jk_bank_arbiter
  import jk_bank_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             VALID_A,
  input  logic [OP_W-1:0]  OP_A,
  input  logic [WIDTH-1:0] MASK_A,
  output logic             READY_A,
  input  logic             VALID_B,
  input  logic [OP_W-1:0]  OP_B,
  input  logic [WIDTH-1:0] MASK_B,
  output logic             READY_B,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QB,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR,
  output logic             OWNER
);

  state_t           state_q, state_d;
  logic [OP_W-1:0]  op_q;
  logic [WIDTH-1:0] mask_q;
  logic             owner_q;
  logic             last_q;  // requester served most recently; reset to B so A wins first
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             win_a, win_b, accept;
  logic [WIDTH-1:0] j, k;

  // Arbitration: a lone requester wins, on contention the one not served last wins.
  always_comb begin
    win_a = VALID_A && (!VALID_B || (last_q == REQ_B));
    win_b = VALID_B && (!VALID_A || (last_q == REQ_A));
  end

  assign READY_A = (state_q == StIdle) && win_a;
  assign READY_B = (state_q == StIdle) && win_b;
  assign accept  = READY_A || READY_B;

  // Next state and completion pulses.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept) state_d = StApply;
      end
      StApply: begin
        if (op_q == OpPulse) begin
          state_d = StRestore;
        end else begin
          state_d = StIdle;
          done_d  = 1'b1;
          err_d   = op_illegal(op_q);
        end
      end
      StRestore: begin
        state_d = StIdle;
        done_d  = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  // J/K decode from the latched command; RESTORE toggles the pulse bits back.
  always_comb begin
    j = '0;
    k = '0;
    case (state_q)
      StApply: begin
        case (op_q)
          OpClr:   k = mask_q;
          OpSet:   j = mask_q;
          OpTgl,
          OpPulse: begin
            j = mask_q;
            k = mask_q;
          end
          default: ;
        endcase
      end
      StRestore: begin
        j = mask_q;
        k = mask_q;
      end
      default: ;
    endcase
  end

  // State, latched command and round-robin pointer.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= StIdle;
      op_q    <= '0;
      mask_q  <= '0;
      owner_q <= REQ_A;
      last_q  <= REQ_B;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      err_q   <= err_d;
      if (accept) begin
        op_q    <= READY_B ? OP_B : OP_A;
        mask_q  <= READY_B ? MASK_B : MASK_A;
        owner_q <= READY_B ? REQ_B : REQ_A;
        last_q  <= READY_B ? REQ_B : REQ_A;
      end
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell u_cell (
      .CLK  (CLK),
      .RST_N(RST_N),
      .J    (j[i]),
      .K    (k[i]),
      .Q    (Q[i]),
      .QB   (QB[i])
    );
  end

  assign BUSY  = (state_q != StIdle);
  assign DONE  = done_q;
  assign ERR   = err_q;
  assign OWNER = owner_q;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations, then random traffic
// compared every cycle against a command-level model.
module tb_jk_bank_arbiter;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       VALID_A, VALID_B;
  logic [2:0] OP_A, OP_B;
  logic [7:0] MASK_A, MASK_B;
  logic       READY_A, READY_B;
  logic [7:0] Q, QB;
  logic       BUSY, DONE, ERR, OWNER;

  jk_bank_arbiter #(.WIDTH(8)) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .VALID_A(VALID_A),
    .OP_A   (OP_A),
    .MASK_A (MASK_A),
    .READY_A(READY_A),
    .VALID_B(VALID_B),
    .OP_B   (OP_B),
    .MASK_B (MASK_B),
    .READY_B(READY_B),
    .Q      (Q),
    .QB     (QB),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .ERR    (ERR),
    .OWNER  (OWNER)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  int last_acc = -1;

  // Command-level model: bank value, edges left for the current command, pending result.
  logic [7:0] m_q;
  int         m_left;
  logic [2:0] m_op;
  logic [7:0] m_mask;
  logic       m_owner, m_last, m_done, m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q = 8'h00; m_left = 0; m_op = 3'd0; m_mask = 8'h00;
    m_owner = 1'b0; m_last = 1'b1; m_done = 1'b0; m_err = 1'b0;
  endtask

  // -1 none, 0 A, 1 B
  function automatic int winner();
    if (m_left != 0) return -1;
    if (VALID_A && VALID_B) return m_last ? 0 : 1;
    if (VALID_A) return 0;
    if (VALID_B) return 1;
    return -1;
  endfunction

  task automatic check_all();
    int w;
    logic [7:0] exp_qb;
    w = winner();
    exp_qb = ~m_q;
    chk("READY_A", READY_A, w == 0);
    chk("READY_B", READY_B, w == 1);
    chk("Q", Q, m_q);
    chk("QB", QB, exp_qb);
    chk("BUSY", BUSY, m_left != 0);
    chk("DONE", DONE, m_done);
    chk("ERR", ERR, m_err);
    chk("OWNER", OWNER, m_owner);
  endtask

  task automatic model_edge(input int w);
    m_done = 1'b0;
    m_err  = 1'b0;
    if (m_left > 0) begin
      case (m_op)
        3'd1:    m_q = m_q & ~m_mask;
        3'd2:    m_q = m_q | m_mask;
        3'd3:    m_q = m_q ^ m_mask;
        3'd4:    m_q = m_q ^ m_mask;
        default: ;
      endcase
      m_left--;
      if (m_left == 0) begin
        m_done = 1'b1;
        m_err  = (m_op > 3'd4);
      end
    end else if (w >= 0) begin
      m_op    = (w == 1) ? OP_B : OP_A;
      m_mask  = (w == 1) ? MASK_B : MASK_A;
      m_owner = (w == 1);
      m_last  = (w == 1);
      m_left  = (m_op == 3'd4) ? 2 : 1;
    end
  endtask

  task automatic step(input logic va, input logic [2:0] oa, input logic [7:0] ma,
                      input logic vb, input logic [2:0] ob, input logic [7:0] mb);
    int w;
    VALID_A = va; OP_A = oa; MASK_A = ma;
    VALID_B = vb; OP_B = ob; MASK_B = mb;
    #1;
    check_all();
    w = winner();
    last_acc = w;
    @(posedge CLK);
    model_edge(w);
    #1;
  endtask

  task automatic cycle(input logic va, input logic [2:0] oa, input logic [7:0] ma,
                       input logic vb, input logic [2:0] ob, input logic [7:0] mb);
    @(negedge CLK);
    step(va, oa, ma, vb, ob, mb);
  endtask

  task automatic idle();
    cycle(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
  endtask

  logic       va, vb;
  logic [2:0] oa, ob;
  logic [7:0] ma, mb;

  initial begin
    RST_N = 1'b0;
    VALID_A = 1'b0; OP_A = 3'd0; MASK_A = 8'h00;
    VALID_B = 1'b0; OP_B = 3'd0; MASK_B = 8'h00;
    model_reset();
    #12;
    chk("rst_Q", Q, 8'h00);
    chk("rst_QB", QB, 8'hFF);
    chk("rst_BUSY", BUSY, 1'b0);
    chk("rst_DONE", DONE, 1'b0);
    chk("rst_OWNER", OWNER, 1'b0);
    @(negedge CLK);
    RST_N = 1'b1;

    // A: SET 0x0F
    cycle(1'b1, 3'd2, 8'h0F, 1'b0, 3'd0, 8'h00);
    chk("set_BUSY", BUSY, 1'b1);
    idle();
    chk("set_Q", Q, 8'h0F);
    chk("set_QB", QB, 8'hF0);
    chk("set_DONE", DONE, 1'b1);
    chk("set_ERR", ERR, 1'b0);
    chk("set_OWNER", OWNER, 1'b0);

    // B: TGL 0xFF, then B: HOLD 0xFF
    cycle(1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 8'hFF);
    idle();
    chk("tgl_Q", Q, 8'hF0);
    chk("tgl_OWNER", OWNER, 1'b1);
    cycle(1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 8'hFF);
    idle();
    chk("hold_Q", Q, 8'hF0);
    chk("hold_DONE", DONE, 1'b1);

    // Contention: A SET bit0, B CLR bit0, alternating grants
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 3'd2, 8'h01, 1'b1, 3'd1, 8'h01);
      cycle(1'b1, 3'd2, 8'h01, 1'b1, 3'd1, 8'h01);
      chk("rr_bit0", Q[0], (i % 2) == 0);
      chk("rr_OWNER", OWNER, (i % 2) == 1);
    end

    // Clear bank, then PULSE 0x80
    cycle(1'b1, 3'd1, 8'hFF, 1'b0, 3'd0, 8'h00);
    idle();
    cycle(1'b1, 3'd4, 8'h80, 1'b0, 3'd0, 8'h00);
    chk("pulse_BUSY0", BUSY, 1'b1);
    idle();
    chk("pulse_Q1", Q, 8'h80);
    chk("pulse_BUSY1", BUSY, 1'b1);
    chk("pulse_DONE1", DONE, 1'b0);
    idle();
    chk("pulse_Q2", Q, 8'h00);
    chk("pulse_DONE2", DONE, 1'b1);
    chk("pulse_BUSY2", BUSY, 1'b0);

    // Illegal opcode from 0x3C
    cycle(1'b1, 3'd2, 8'h3C, 1'b0, 3'd0, 8'h00);
    idle();
    cycle(1'b1, 3'd5, 8'hFF, 1'b0, 3'd0, 8'h00);
    idle();
    chk("ill_Q", Q, 8'h3C);
    chk("ill_DONE", DONE, 1'b1);
    chk("ill_ERR", ERR, 1'b1);
    idle();
    chk("ill_DONE_off", DONE, 1'b0);
    chk("ill_ERR_off", ERR, 1'b0);

    // Reset during RESTORE
    cycle(1'b1, 3'd4, 8'h80, 1'b0, 3'd0, 8'h00);
    cycle(1'b1, 3'd4, 8'h80, 1'b1, 3'd0, 8'h00);
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    chk("arst_Q", Q, 8'h00);
    chk("arst_QB", QB, 8'hFF);
    chk("arst_BUSY", BUSY, 1'b0);
    model_reset();
    @(posedge CLK);
    #1;
    chk("arst_DONE", DONE, 1'b0);
    @(negedge CLK);
    RST_N = 1'b1;
    VALID_A = 1'b1; VALID_B = 1'b1;
    #1;
    chk("arst_READY_A", READY_A, 1'b1);
    chk("arst_READY_B", READY_B, 1'b0);
    step(1'b1, 3'd0, 8'h00, 1'b1, 3'd0, 8'h00);

    // Random traffic
    va = 1'b0; vb = 1'b0; oa = 3'd0; ob = 3'd0; ma = 8'h00; mb = 8'h00;
    for (int n = 0; n < 2000; n++) begin
      if (!(va && last_acc != 0 && $urandom_range(7) != 0)) begin
        va = 1'($urandom_range(1));
        oa = 3'($urandom_range(7));
        ma = ($urandom_range(9) == 0) ? 8'h00 : 8'($urandom);
      end
      if (!(vb && last_acc != 1 && $urandom_range(7) != 0)) begin
        vb = 1'($urandom_range(1));
        ob = 3'($urandom_range(7));
        mb = ($urandom_range(9) == 0) ? 8'h00 : 8'($urandom);
      end
      cycle(va, oa, ma, vb, ob, mb);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jk_bank_arbiter.md
# jk_bank_arbiter

Two-requester, round-robin controller that owns a bank of WIDTH JK flip-flop cells. It accepts masked bit-operations (clear, set, toggle, pulse) over a valid/ready handshake, drives the J/K inputs of the bank, and reports completion. It is the only writer of the bank and sits between control-side requesters and any logic that reads the bank state.

## Interface
- WIDTH, 8, number of JK cells in the bank (≥1)
- CLK  in  1  clock; all state changes on the rising edge
- RST_N  in  1  reset, asynchronous, active-low
- VALID_A  in  1  requester A has a command
- OP_A  in  3  requester A operation code
- MASK_A  in  WIDTH  requester A bit select
- READY_A  out  1  requester A command accepted this edge if VALID_A
- VALID_B, OP_B, MASK_B, READY_B  same as the A set, for requester B
- Q  out  WIDTH  bank state
- QB  out  WIDTH  ~Q
- BUSY  out  1  command in progress (state ≠ IDLE)
- DONE  out  1  one-cycle pulse, command completed
- ERR  out  1  one-cycle pulse with DONE, illegal opcode completed
- OWNER  out  1  requester of the most recently accepted command (0=A, 1=B)

## Operation
- Opcodes: 000 HOLD (J=K=0), 001 CLR (K=1), 010 SET (J=1), 011 TGL (J=K=1), 100 PULSE (toggle, then toggle back). Codes 101–111 are executed as HOLD and set ERR with DONE.
- Mask: bits with mask=0 get J=K=0 and never change. Mask 0 is legal; it completes as a no-op.
- FSM states: IDLE, APPLY, RESTORE.
  - IDLE → APPLY on acceptance.
  - APPLY → IDLE for all opcodes except PULSE.
  - APPLY → RESTORE for PULSE.
  - RESTORE → IDLE.
- J/K are decoded from the latched opcode and mask during APPLY and RESTORE. In IDLE, J=K=0 for all cells.
- Arbitration happens only in IDLE:
  - If only one requester is valid, it wins.
  - If both are valid, the requester not served last wins. The pointer initialises after reset so that A wins first.
- READY_x = (state==IDLE) && (x wins). READY_x is combinational from both VALIDs and the pointer, and is never high in APPLY or RESTORE.
- Acceptance is VALID_x && READY_x at a rising edge. At that edge, OP, MASK and requester id are latched, OWNER and the pointer update, and the state moves to APPLY.
- Requesters must hold OP/MASK stable while VALID is high and not accepted.
- Reset values: Q=0, QB=all ones, state=IDLE, BUSY=0, DONE=0, ERR=0, OWNER=0, pointer favours A.

## Timing
- Acceptance at edge t.
- Non-PULSE command: bank updates at edge t+1. DONE (and ERR if applicable) is high for the cycle after t+1. The state is IDLE again after t+1, so READY can be high in that same cycle. Throughput is one command per 2 cycles.
- PULSE: masked bits invert at t+1 and restore at t+2. DONE is high for the cycle after t+2. BUSY is high for 2 cycles.
- BUSY is registered and equals state≠IDLE. It is high from t until edge t+1 (or t+2 for PULSE).
- A requester holding VALID after its acceptance re-competes in the next IDLE cycle. If the other requester is also valid, the other one wins.
- Reset asserted mid-command (APPLY or RESTORE) is immediate and asynchronous: the bank clears, the command is discarded and no DONE is produced. The first acceptance after release goes to A if both requesters are valid.
- VALID may be withdrawn before acceptance without effect.

## Structure
- Package jk_bank_pkg holds:
  - op_t enum (HOLD, CLR, SET, TGL, PULSE)
  - state_t enum (IDLE, APPLY, RESTORE)
  - REQ_A/REQ_B constants
  - opcode width constant (3)
- Sub-module jk_cell: a single JK flip-flop with CLK, RST_N (async active-low, Q=0), J, K, Q, QB. Standard JK semantics: 00 hold, 01 clear, 10 set, 11 toggle. It is instantiated WIDTH times in a generate loop.
- The arbiter FSM, latch registers and J/K decode live in jk_bank_arbiter.

## Test plan (WIDTH=8)
- Reset, then A: SET mask 0x0F → READY_A=1 at acceptance, Q=0x0F and QB=0xF0 after t+1, DONE one cycle, OWNER=0, ERR=0.
- From Q=0x0F, B: TGL mask 0xFF → Q=0xF0 after t+1, OWNER=1; a following B: HOLD mask 0xFF leaves Q=0xF0 and DONE pulses.
- A (SET mask 0x01) and B (CLR mask 0x01) both held valid from reset → grants A,B,A,B, one every 2 cycles; Q bit0 sequence 1,0,1,0; READY never high in APPLY.
- From Q=0x00, A: PULSE mask 0x80 → Q=0x80 after t+1, Q=0x00 after t+2; BUSY high 2 cycles; single DONE after t+2 only.
- A: opcode 101 mask 0xFF from Q=0x3C → Q stays 0x3C; DONE and ERR pulse together for one cycle.
- A: PULSE mask 0x80, RST_N low during RESTORE → Q=0x00 and QB=0xFF immediately, no DONE. After release with both valid, READY_A=1 and READY_B=0.
